// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: types and constants shared by the memory port arbiter.
//   mem_req_t   - payload presented on the memory bus (we, addr, wdata, be)
//   arb_state_t - arbiter ownership state (IDLE, IF_WAIT, LS_WAIT)
//   BE_ALL      - full-word byte enable used by instruction fetch
//   wd_width()  - watchdog counter width for a given timeout limit (8..32)
// The struct is sized by MEM_ADDR_W/MEM_DATA_W. These are the widest ports
// the arbiter can carry without truncating the bus payload.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  localparam logic [MEM_BE_W-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LS_WAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BE_W-1:0]   be;
  } mem_req_t;

  // Counter wide enough to hold the limit, clamped to 8..32 bits.
  function automatic int wd_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: response watchdog for the memory port arbiter.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - zero the counter (arbiter is entering a WAIT state)
//   enable     - a WAIT cycle without a response; counts this cycle
//   expired    - this enabled cycle brings the count to LIMIT
module mem_arb_watchdog
  import mem_bus_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = wd_width(LIMIT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Fires in the cycle whose increment would reach LIMIT, so the owner sees
  // its timeout response in exactly the LIMIT-th WAIT cycle.
  assign expired = enable && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch
// (if_*) and the load/store unit (ls_*), one transaction outstanding.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt        - fetch request/grant
//   if_rvalid/if_rdata              - fetch response
//   ls_req/ls_we/ls_addr/ls_wdata/ls_be -> ls_gnt - load/store request/grant
//   ls_rvalid/ls_rdata              - load data or store acknowledge (rdata 0)
//   mem_req/we/addr/wdata/be, mem_gnt, mem_rvalid, mem_rdata - memory bus
//   bus_err                         - timeout marker on a response pulse
//   core_stall                      - core must hold while requests are unanswered
// Optional: define MEM_ARB_TIMEOUT_EN to add a response watchdog of
// TIMEOUT_CYCLES; otherwise bus_err is 0 and WAIT states hold indefinitely.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err,
  output logic                core_stall
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state_reg, state_next;
  logic       store_reg, store_next;
  logic       in_wait, arb_point, expired;
  mem_req_t   win;

  assign in_wait   = (state_reg != IDLE);
  // A response frees the port in the same cycle, allowing back-to-back issue.
  assign arb_point = !in_wait || mem_rvalid;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (if_gnt || ls_gnt),
    .enable  (in_wait && !mem_rvalid),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    win        = '0;
    mem_req    = 1'b0;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    bus_err    = 1'b0;
    core_stall = 1'b0;
    state_next = state_reg;
    store_next = store_reg;

    // Reset forces every output to 0 even though most are combinational.
    if (rst_n) begin
      if (arb_point) begin
        if (ls_req) begin
          mem_req   = 1'b1;
          win.we    = ls_we;
          win.addr  = MEM_ADDR_W'(ls_addr);
          win.wdata = MEM_DATA_W'(ls_wdata);
          win.be    = MEM_BE_W'(ls_be);
          ls_gnt    = mem_gnt;
        end else if (if_req) begin
          mem_req  = 1'b1;
          win.addr = MEM_ADDR_W'(if_addr);
          win.be   = BE_ALL;
          if_gnt   = mem_gnt;
        end
        if (ls_gnt) begin
          state_next = LS_WAIT;
          store_next = ls_we;
        end else if (if_gnt) begin
          state_next = IF_WAIT;
        end else begin
          state_next = IDLE;
        end
      end else if (expired) begin
        state_next = IDLE;
      end

      // A timeout answers the owner with zero data; a stray rvalid in IDLE
      // matches no case arm and is dropped.
      if (mem_rvalid || expired) begin
        unique case (state_reg)
          IF_WAIT: begin
            if_rvalid = 1'b1;
            if_rdata  = expired ? '0 : mem_rdata;
            bus_err   = expired;
          end
          LS_WAIT: begin
            ls_rvalid = 1'b1;
            ls_rdata  = (expired || store_reg) ? '0 : mem_rdata;
            bus_err   = expired;
          end
          default: ;
        endcase
      end

      core_stall = (if_req && !if_rvalid) || (ls_req && !ls_rvalid) ||
                   (in_wait && !mem_rvalid);
    end
  end

  assign mem_we    = win.we;
  assign mem_addr  = ADDR_W'(win.addr);
  assign mem_wdata = DATA_W'(win.wdata);
  assign mem_be    = BE_W'(win.be);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      store_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      store_reg <= store_next;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory bus port between instruction fetch and the load/store unit.
- Sequences each transaction through grant and response phases.
- Generates the core stall so the core can run single-ported memory.
- Sits between the core front-end/LSU (driven by decoded ld_st_unit micro-code) and the memory system.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-enable width is DATA_W/8
TIMEOUT_CYCLES, 255, response watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch response valid, one-cycle pulse
if_rdata  out  DATA_W  fetch read data
ls_req  in  1  load/store request, held until ls_gnt
ls_we  in  1  1 = store
ls_addr  in  ADDR_W  load/store byte address
ls_wdata  in  DATA_W  store data
ls_be  in  DATA_W/8  byte enables
ls_gnt  out  1  load/store request accepted this cycle
ls_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse
ls_rdata  out  DATA_W  load data; 0 for store acknowledges
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_be  out  DATA_W/8  bus byte enables
mem_gnt  in  1  bus accepted request
mem_rvalid  in  1  bus response valid
mem_rdata  in  DATA_W  bus read data
bus_err  out  1  pulse with *_rvalid when a transaction timed out
core_stall  out  1  high while any asserted requester has not yet received its response

Behaviour:
- Protocol: request/grant, then response. At most one transaction outstanding.
- Transfer occurs when mem_req && mem_gnt.
- Every transaction, store included, gets exactly one mem_rvalid.
- States: IDLE, IF_WAIT, LS_WAIT.
- Arbitration point: state IDLE, or a WAIT state in a cycle where mem_rvalid=1 (back-to-back issue allowed).
- At an arbitration point:
  - ls_req has fixed priority over if_req.
  - mem_* is driven combinationally from the winner.
  - Fetch drives mem_we=0 and mem_be=all ones.
  - With no requester, mem_req=0 and all mem_* payload outputs are 0.
- Grant: if_gnt/ls_gnt = winner && mem_gnt, same cycle. On grant, next state is IF_WAIT or LS_WAIT per owner; otherwise IDLE.
- Not at an arbitration point (WAIT, no rvalid): mem_req=0, both gnt=0.
- Response routing:
  - In IF_WAIT, mem_rvalid gives if_rvalid=1, if_rdata=mem_rdata.
  - In LS_WAIT, mem_rvalid gives ls_rvalid=1; ls_rdata=mem_rdata for loads, 0 for stores (store flag registered at grant).
  - Non-owner rvalid/rdata stay 0.
- Latency: zero-wait bus (gnt same cycle, rvalid next cycle) gives one transaction per cycle.
- Stray mem_rvalid in IDLE: dropped, no output pulse.
- core_stall = (if_req && !if_rvalid) || (ls_req && !ls_rvalid) || (state==LS_WAIT && !mem_rvalid) || (state==IF_WAIT && !mem_rvalid).
- Reset (rst_n low, asynchronous): state to IDLE, registered store flag to 0, all outputs 0 regardless of inputs. An in-flight transaction is abandoned; its late rvalid after reset is dropped as stray.
- Requester dropping req before gnt: protocol violation, undefined; assertion in bench.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entering a WAIT state and increments each WAIT cycle without mem_rvalid.
  - On reaching TIMEOUT_CYCLES, the owner gets *_rvalid=1, *_rdata=0, bus_err=1 for one cycle, and the state returns to IDLE.
  - A later stray rvalid is dropped only if it arrives in IDLE.
- Undefined: no counter, bus_err tied 0, WAIT is held indefinitely.

Decomposition:
- Package mem_bus_pkg:
  - struct mem_req_t {we, addr, wdata, be}
  - enum arb_state_t {IDLE, IF_WAIT, LS_WAIT}
  - localparam BE_ALL
- One sub-module mem_arb_watchdog: counter, clear/enable inputs, expired output. Instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Single fetch, zero-wait: if_req=1, if_addr=0x100, mem_gnt=1, next cycle mem_rvalid=1, mem_rdata=0x00000013 -> if_gnt same cycle, if_rvalid=1, if_rdata=0x13 next cycle, bus_err=0.
- Simultaneous requests: if_req=ls_req=1, ls_addr=0x2000, ls_we=0 -> mem_addr=0x2000, ls_gnt first; fetch granted in the ls rvalid cycle; two rvalids in order ls then if.
- Store acknowledge: ls_we=1, ls_be=4'b0011, ls_wdata=0xDEADBEEF, mem_rdata=0xFFFFFFFF on response -> mem_be=0011, ls_rvalid=1, ls_rdata=0, core_stall low after ack.
- Wait-state bus: mem_gnt low 3 cycles, rvalid 2 cycles after gnt -> mem_req held, gnt/rvalid exactly once, core_stall high for every cycle until response.
- Mid-transaction reset: rst_n low during LS_WAIT, then mem_rvalid pulses after release -> outputs 0 during reset, stray rvalid dropped, no ls_rvalid.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no rvalid -> ls_rvalid=1 and bus_err=1 exactly 4 WAIT cycles after grant, state IDLE, next fetch serviced normally.
